ycr_tcm_mbank: RTL
==================

YCR_TCM_MBANK -- requirements
Module: ycr_tcm_mbank

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4, the number of single-port SRAM banks (power of 2, 2..8).
REQ-002 SHALL have parameter BANK_AW, default 9, the word-address width of each bank (512 x 32b).
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  core clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- imem_req  in  1  instruction fetch request.
- imem_addr  in  32  fetch byte address.
- imem_req_ack  out  1  fetch accepted this cycle.
- imem_rdata  out  32  fetch data.
- imem_resp  out  2  fetch response code.
- dmem_req  in  1  data request.
- dmem_cmd  in  1  data command (RD/WR).
- dmem_width  in  2  access width (BYTE/HWORD/WORD).
- dmem_addr  in  32  data byte address.
- dmem_wdata  in  32  write data.
- dmem_req_ack  out  1  data request accepted this cycle.
- dmem_rdata  out  32  read data, right-aligned.
- dmem_resp  out  2  data response code.
- bank_csb  out  NUM_BANKS  per-bank chip select, active low.
- bank_web  out  NUM_BANKS  per-bank write enable, active low.
- bank_addr  out  NUM_BANKS*BANK_AW  per-bank word address.
- bank_wmask  out  NUM_BANKS*4  per-bank byte write mask.
- bank_din  out  NUM_BANKS*32  per-bank write data.
- bank_dout  in  NUM_BANKS*32  per-bank read data, valid the cycle after csb low.

Function
REQ-005 SHALL decode word index = addr[BANK_AW+1:2], bank = addr[BANK_AW+1+log2(NUM_BANKS):BANK_AW+2]; higher bits ignored.
REQ-006 SHALL assert req_ack combinationally in the cycle a request is granted; a request not acked SHALL be held by the requester.
REQ-007 SHALL grant both ports in the same cycle when their banks differ.
REQ-008 SHALL, on same-bank conflict, grant one port via a 1-bit round-robin pointer (reset: dmem first), toggled after each conflict grant.
REQ-009 SHALL drive a granted bank: csb=0; web=0 only for dmem WR; wmask BYTE=0001<<addr[1:0], HWORD=0011<<{addr[1],0}, WORD=1111; din = wdata replicated for BYTE/HWORD.
REQ-010 SHALL drive all ungranted banks with csb=1, web=1, wmask=0.
REQ-011 SHALL, for a read granted in cycle T, register bank_dout at the end of T+1 and present rdata with resp=RDY_OK in cycle T+2 for exactly one cycle.
REQ-012 SHALL, for a write granted in T, present resp=RDY_OK in T+2, rdata unchanged.
REQ-013 SHALL accept back-to-back requests every cycle per port, returning responses in order, one per ack.
REQ-014 SHALL shift dmem read data right by 8*addr[1:0] captured at grant.
REQ-015 SHALL treat misaligned requests (imem addr[1:0]!=0; dmem HWORD addr[0]=1; dmem WORD addr[1:0]!=0) as: ack in arbitration order, no bank access, resp=RDY_ER at T+2.
REQ-016 SHALL drive resp=NOTRDY in every cycle without a response.

Reset
REQ-017 SHALL, while rst=1, drive req_acks 0, resps NOTRDY, rdatas 0, bank_csb/web all ones, wmask 0, pointer dmem-first.
REQ-018 SHALL discard all in-flight responses on reset; no response after rst deasserts for pre-reset acks.

Configuration
REQ-019 SHALL, with YCR_TCM_RDREG_EN defined, add one output register stage on both response paths (latency T+3); without it, latency T+2.
REQ-020 SHALL otherwise keep identical behaviour, including ordering and error responses, under both settings.

Verification
REQ-021 imem RD 0x000, dmem RD 0x804 same cycle (banks 0/1) -> both acked in T, both RDY_OK in T+2.
REQ-022 imem and dmem RD both bank 0, three cycles held -> acks alternate dmem, imem, dmem; resps in grant order.
REQ-023 dmem WR BYTE addr 0x003 wdata 0xA5 -> bank0 wmask 1000, din 0xA5A5A5A5; RD WORD 0x000 returns 0xA5 in [31:24].
REQ-024 dmem RD HWORD addr 0x001 -> ack, all csb high, resp RDY_ER in T+2.
REQ-025 rst asserted in T+1 after a read grant -> no RDY_OK after release; outputs at reset values.
REQ-026 Rebuild with YCR_TCM_RDREG_EN, repeat REQ-021 -> RDY_OK in T+3.

Source files
------------

// File: rtl/ycr_tcm_mbank.sv
// Dual-port (imem/dmem) arbiter onto NUM_BANKS single-port SRAM banks with in-order responses.
// Optional macro YCR_TCM_RDREG_EN adds one output register stage on both response paths.
module ycr_tcm_mbank #(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned BANK_AW   = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         imem_req,
  input  logic [31:0]                  imem_addr,
  output logic                         imem_req_ack,
  output logic [31:0]                  imem_rdata,
  output logic [1:0]                   imem_resp,
  input  logic                         dmem_req,
  input  logic                         dmem_cmd,
  input  logic [1:0]                   dmem_width,
  input  logic [31:0]                  dmem_addr,
  input  logic [31:0]                  dmem_wdata,
  output logic                         dmem_req_ack,
  output logic [31:0]                  dmem_rdata,
  output logic [1:0]                   dmem_resp,
  output logic [NUM_BANKS-1:0]         bank_csb,
  output logic [NUM_BANKS-1:0]         bank_web,
  output logic [NUM_BANKS*BANK_AW-1:0] bank_addr,
  output logic [NUM_BANKS*4-1:0]       bank_wmask,
  output logic [NUM_BANKS*32-1:0]      bank_din,
  input  logic [NUM_BANKS*32-1:0]      bank_dout
);
  localparam int unsigned BW  = $clog2(NUM_BANKS);
  localparam int unsigned BLO = BANK_AW + 2;
  localparam int unsigned BHI = BANK_AW + 1 + BW;

  localparam logic [1:0] RESP_NOTRDY = 2'd0;
  localparam logic [1:0] RESP_OK     = 2'd1;
  localparam logic [1:0] RESP_ER     = 2'd2;
  localparam logic       CMD_WR      = 1'b1;
  localparam logic [1:0] W_BYTE      = 2'd0;
  localparam logic [1:0] W_HWORD     = 2'd1;

  logic [BW-1:0]      i_bank, d_bank;
  logic [BANK_AW-1:0] i_word, d_word;
  logic               i_err, d_err, conflict, i_gnt, d_gnt, rr_ptr;
  logic [3:0]         d_wmask;
  logic [31:0]        d_din;
  logic [31:0]        dout_w [NUM_BANKS];

  logic               i1_vld, i1_err, d1_vld, d1_err, d1_rd;
  logic [BW-1:0]      i1_bank, d1_bank;
  logic [1:0]         d1_shift;
  logic [1:0]         i2_resp, d2_resp;
  logic [31:0]        i2_rdata, d2_rdata;

  logic unused_addr;
  assign unused_addr = ^{imem_addr[31:BHI+1], dmem_addr[31:BHI+1]};

  assign i_bank = imem_addr[BHI:BLO];
  assign d_bank = dmem_addr[BHI:BLO];
  assign i_word = imem_addr[BANK_AW+1:2];
  assign d_word = dmem_addr[BANK_AW+1:2];
  assign i_err  = (imem_addr[1:0] != 2'b00);

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_dout
    assign dout_w[g] = bank_dout[g*32 +: 32];
  end

  // dmem width decode: misalignment, byte mask and lane-replicated write data
  always_comb begin
    d_err   = 1'b0;
    d_wmask = 4'b1111;
    d_din   = dmem_wdata;
    case (dmem_width)
      W_BYTE: begin
        d_wmask = 4'b0001 << dmem_addr[1:0];
        d_din   = {4{dmem_wdata[7:0]}};
      end
      W_HWORD: begin
        d_err   = dmem_addr[0];
        d_wmask = 4'b0011 << {dmem_addr[1], 1'b0};
        d_din   = {2{dmem_wdata[15:0]}};
      end
      default: d_err = (dmem_addr[1:0] != 2'b00);
    endcase
  end

  // rr_ptr=0 favours dmem on a same-bank conflict
  assign conflict     = imem_req & dmem_req & (i_bank == d_bank);
  assign i_gnt        = ~rst & imem_req & (~conflict |  rr_ptr);
  assign d_gnt        = ~rst & dmem_req & (~conflict | ~rr_ptr);
  assign imem_req_ack = i_gnt;
  assign dmem_req_ack = d_gnt;

  always_comb begin
    bank_csb   = '1;
    bank_web   = '1;
    bank_addr  = '0;
    bank_wmask = '0;
    bank_din   = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (i_gnt && !i_err && (i_bank == BW'(b))) begin
        bank_csb[b]                   = 1'b0;
        bank_addr[b*BANK_AW +: BANK_AW] = i_word;
        bank_wmask[b*4 +: 4]          = 4'b1111;
      end
      if (d_gnt && !d_err && (d_bank == BW'(b))) begin
        bank_csb[b]                   = 1'b0;
        bank_web[b]                   = (dmem_cmd != CMD_WR);
        bank_addr[b*BANK_AW +: BANK_AW] = d_word;
        bank_wmask[b*4 +: 4]          = d_wmask;
        bank_din[b*32 +: 32]          = d_din;
      end
    end
  end

  // grant -> SRAM read cycle -> registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= 1'b0;
      i1_vld   <= 1'b0;
      i1_err   <= 1'b0;
      i1_bank  <= '0;
      d1_vld   <= 1'b0;
      d1_err   <= 1'b0;
      d1_rd    <= 1'b0;
      d1_bank  <= '0;
      d1_shift <= 2'b00;
      i2_resp  <= RESP_NOTRDY;
      d2_resp  <= RESP_NOTRDY;
      i2_rdata <= '0;
      d2_rdata <= '0;
    end else begin
      if (conflict) rr_ptr <= ~rr_ptr;
      i1_vld   <= i_gnt;
      i1_err   <= i_err;
      i1_bank  <= i_bank;
      d1_vld   <= d_gnt;
      d1_err   <= d_err;
      d1_rd    <= (dmem_cmd != CMD_WR);
      d1_bank  <= d_bank;
      d1_shift <= dmem_addr[1:0];
      i2_resp  <= RESP_NOTRDY;
      d2_resp  <= RESP_NOTRDY;
      if (i1_vld) begin
        if (i1_err) begin
          i2_resp <= RESP_ER;
        end else begin
          i2_resp  <= RESP_OK;
          i2_rdata <= dout_w[i1_bank];
        end
      end
      if (d1_vld) begin
        if (d1_err) begin
          d2_resp <= RESP_ER;
        end else begin
          d2_resp <= RESP_OK;
          if (d1_rd) d2_rdata <= dout_w[d1_bank] >> {d1_shift, 3'b000};
        end
      end
    end
  end

`ifdef YCR_TCM_RDREG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_resp  <= RESP_NOTRDY;
      dmem_resp  <= RESP_NOTRDY;
      imem_rdata <= '0;
      dmem_rdata <= '0;
    end else begin
      imem_resp  <= i2_resp;
      dmem_resp  <= d2_resp;
      imem_rdata <= i2_rdata;
      dmem_rdata <= d2_rdata;
    end
  end
`else
  assign imem_resp  = i2_resp;
  assign dmem_resp  = d2_resp;
  assign imem_rdata = i2_rdata;
  assign dmem_rdata = d2_rdata;
`endif

endmodule
